// File: rtl/tx_scrambler_seq.sv
// 64b/66b transmit path: accepts blocks on gearbox demand, inserts idle blocks on
// underflow, scrambles payload with 1+x^39+x^58 and emits 32-bit half-blocks.
module tx_scrambler_seq #(
  parameter logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E,
  parameter logic [57:0] SCR_INIT   = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] blk_data_i,
  input  logic [1:0]  blk_head_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] data_o,
  output logic [1:0]  head_o,
  output logic [6:0]  sequence_o,
  output logic [15:0] underflow_cnt_o
);

  logic [6:0]  seq_q, seq_d, seq_nxt;
  logic [31:0] data_q, data_d;
  logic [31:0] hi_q, hi_d;
  logic [1:0]  head_q, head_d;
  logic [57:0] scr_q, scr_d;
  logic [15:0] ufl_q, ufl_d;

  logic        ready;
  logic [63:0] blk_pl;
  logic [1:0]  blk_hd;
  logic [63:0] scr_out;
  logic [57:0] scr_walk;

  // Ready whenever the next sequence slot starts a block (even, below the pause).
  assign ready = !rst_i && seq_q[0] && (seq_q != 7'd63);

  assign blk_pl = blk_valid_i ? blk_data_i : IDLE_BLOCK;
  assign blk_hd = blk_valid_i ? blk_head_i : 2'b10;

  // Bit-serial scrambler unrolled over the 64 payload bits; scr_walk[0] is the newest bit.
  always_comb begin
    scr_out  = '0;
    scr_walk = scr_q;
    for (int unsigned i = 0; i < 64; i++) begin
      scr_out[i] = blk_pl[i] ^ scr_walk[38] ^ scr_walk[57];
      scr_walk   = {scr_walk[56:0], scr_out[i]};
    end
  end

  always_comb begin
    seq_nxt = (seq_q == 7'd65) ? '0 : seq_q + 7'd1;
    seq_d   = seq_nxt;
    data_d  = '0;
    head_d  = '0;
    hi_d    = hi_q;
    scr_d   = scr_q;
    ufl_d   = ufl_q;
    if (ready) begin
      data_d = scr_out[31:0];
      head_d = blk_hd;
      hi_d   = scr_out[63:32];
      scr_d  = scr_walk;
      if (!blk_valid_i && (ufl_q != 16'hFFFF)) begin
        ufl_d = ufl_q + 16'd1;
      end
    end else if (seq_nxt[0] && (seq_nxt < 7'd64)) begin
      data_d = hi_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q  <= 7'd65;
      data_q <= '0;
      head_q <= '0;
      hi_q   <= '0;
      scr_q  <= SCR_INIT;
      ufl_q  <= '0;
    end else begin
      seq_q  <= seq_d;
      data_q <= data_d;
      head_q <= head_d;
      hi_q   <= hi_d;
      scr_q  <= scr_d;
      ufl_q  <= ufl_d;
    end
  end

  assign blk_ready_o     = ready;
  assign data_o          = data_q;
  assign head_o          = head_q;
  assign sequence_o      = seq_q;
  assign underflow_cnt_o = ufl_q;

endmodule

// File: tb/tb_tx_scrambler_seq.sv
// Self-checking bench for tx_scrambler_seq: directed table, corner sequences and
// randomized traffic against a bit-stream / half-word queue reference model.
module tb_tx_scrambler_seq;

  localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;
  localparam logic [57:0] INIT = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] blk_data_i = '0;
  logic [1:0]  blk_head_i = '0;
  logic        blk_valid_i = 1'b0;
  logic        blk_ready_o;
  logic [31:0] data_o;
  logic [1:0]  head_o;
  logic [6:0]  sequence_o;
  logic [15:0] underflow_cnt_o;

  tx_scrambler_seq #(.IDLE_BLOCK(IDLE), .SCR_INIT(INIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .blk_data_i(blk_data_i), .blk_head_i(blk_head_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .data_o(data_o),
    .head_o(head_o), .sequence_o(sequence_o), .underflow_cnt_o(underflow_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] d; logic [1:0] h; } half_t;
  half_t       hq[$];
  bit          hist[$];
  int          m_seq = 0;
  logic [15:0] m_ufl = '0;
  logic [31:0] e_data = '0;
  logic [1:0]  e_head = '0;
  logic        last_rdy = 1'b0;

  typedef struct {
    logic rst; logic v; logic [63:0] d; logic [1:0] h;
    logic ex_rdy; logic [6:0] ex_seq; logic [1:0] ex_head; logic chk_d; logic [31:0] ex_d;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    logic [57:0] init_v;
    init_v = INIT;
    hist.delete();
    for (int k = 57; k >= 0; k--) hist.push_back(init_v[k]);
    hq.delete();
    m_seq  = 65;
    m_ufl  = '0;
    e_data = '0;
    e_head = '0;
  endfunction

  // Stream model: each output bit xors the input with the scrambled bits 39 and 58 back.
  function automatic logic [63:0] scramble(input logic [63:0] d);
    logic [63:0] r;
    int n;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      n = hist.size();
      r[i] = d[i] ^ hist[n-39] ^ hist[n-58];
      hist.push_back(r[i]);
    end
    while (hist.size() > 58) void'(hist.pop_front());
    return r;
  endfunction

  function automatic logic [63:0] descramble(input logic [63:0] sc);
    bit h[$];
    logic [57:0] init_v;
    logic [63:0] r;
    int n;
    init_v = INIT;
    r = '0;
    for (int k = 57; k >= 0; k--) h.push_back(init_v[k]);
    for (int i = 0; i < 64; i++) begin
      n = h.size();
      r[i] = sc[i] ^ h[n-39] ^ h[n-58];
      h.push_back(sc[i]);
    end
    return r;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [63:0] d, input logic [1:0] h);
    int nx;
    logic exp_rdy;
    logic [63:0] sc;
    half_t hw;
    rst_i = r; blk_valid_i = v; blk_data_i = d; blk_head_i = h;
    #1;
    nx = (m_seq + 1) % 66;
    exp_rdy = !r && (nx % 2 == 0) && (nx < 64);
    last_rdy = blk_ready_o;
    chk("ready", {63'b0, blk_ready_o}, {63'b0, exp_rdy});
    @(posedge clk_i);
    if (r) begin
      model_reset();
    end else begin
      if (exp_rdy) begin
        if (!v && m_ufl != 16'hFFFF) m_ufl++;
        sc = scramble(v ? d : IDLE);
        hq.push_back('{sc[31:0], v ? h : 2'b10});
        hq.push_back('{sc[63:32], 2'b00});
      end
      m_seq = nx;
      if (m_seq >= 64) begin
        e_data = '0; e_head = '0;
      end else if (hq.size() == 0) begin
        checks++; errors++;
        $display("FAIL model_queue: got empty required half-word at seq %0d", m_seq);
      end else begin
        hw = hq.pop_front();
        e_data = hw.d; e_head = hw.h;
      end
    end
    @(negedge clk_i);
    chk("sequence", {57'b0, sequence_o}, m_seq);
    chk("data", {32'b0, data_o}, {32'b0, e_data});
    chk("head", {62'b0, head_o}, {62'b0, e_head});
    chk("underflow", {48'b0, underflow_cnt_o}, {48'b0, m_ufl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lo_cap, hi_cap;
    int cnt, hcnt, guard;
    lo_cap = '0; hi_cap = '0;

    // rst, v, data, head, ready, seq after, head after, check data, data after
    tbl[0] = '{1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 7'd65, 2'b00, 1'b1, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 64'h0, 2'b00, 1'b0, 7'd65, 2'b00, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 64'h0, 2'b01, 1'b1, 7'd0,  2'b01, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 64'hDEAD_BEEF_0000_1111, 2'b01, 1'b0, 7'd1, 2'b00, 1'b1, 32'h03FF_FF80};
    tbl[4] = '{1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b1, 7'd2, 2'b11, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 64'h0, 2'b10, 1'b0, 7'd3, 2'b00, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 7'd4, 2'b10, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 7'd5, 2'b00, 1'b0, 32'h0};

    @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].h);
      chk("tbl_ready", {63'b0, last_rdy}, {63'b0, tbl[i].ex_rdy});
      chk("tbl_seq", {57'b0, sequence_o}, {57'b0, tbl[i].ex_seq});
      chk("tbl_head", {62'b0, head_o}, {62'b0, tbl[i].ex_head});
      if (tbl[i].chk_d) chk("tbl_data", {32'b0, data_o}, {32'b0, tbl[i].ex_d});
      if (i == 2) lo_cap = data_o;
      if (i == 3) hi_cap = data_o;
    end
    chk("descramble", descramble({hi_cap, lo_cap}), 64'h0);

    // Reset pulse at sequence 10, mid-traffic: scrambler must restart from INIT.
    guard = 0;
    while (m_seq != 10 && guard < 100) begin
      cycle(1'b0, 1'b0, 64'h0, 2'b00);
      guard++;
    end
    chk("reach_seq10", {57'b0, sequence_o}, 64'd10);
    cycle(1'b1, 1'b1, 64'h0, 2'b01);
    chk("rst_seq", {57'b0, sequence_o}, 64'd65);
    chk("rst_data", {32'b0, data_o}, 64'h0);
    chk("rst_ufl", {48'b0, underflow_cnt_o}, 64'h0);
    cycle(1'b0, 1'b1, 64'h0, 2'b01);
    chk("restart_lo", {32'b0, data_o}, 64'h0);
    cycle(1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000, 2'b01);
    chk("restart_hi", {32'b0, data_o}, 64'h03FF_FF80);

    // Pause slots with a block held upstream, emitted at sequence 0.
    guard = 0;
    while (m_seq != 0 && guard < 100) begin
      cycle(1'b0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 2'b01);
      if (m_seq >= 64) chk("pause_data", {32'b0, data_o}, 64'h0);
      guard++;
    end
    chk("held_head", {62'b0, head_o}, 64'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 264; i++) begin
      cycle($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    end

    // Back-to-back valid blocks: 32 acceptances and 32 headers per 66 cycles.
    cycle(1'b1, 1'b0, 64'h0, 2'b00);
    cnt = 0; hcnt = 0;
    for (int i = 0; i < 66; i++) begin
      cycle(1'b0, 1'b1, 64'(i), 2'b01);
      if (last_rdy) cnt++;
      if (head_o != 2'b00) hcnt++;
    end
    chk("ready_count", 64'(cnt), 64'd32);
    chk("header_count", 64'(hcnt), 64'd32);

    // No upstream data for one full period: 32 idle insertions.
    cycle(1'b1, 1'b0, 64'h0, 2'b00);
    for (int i = 0; i < 66; i++) cycle(1'b0, 1'b0, 64'h0, 2'b00);
    chk("idle_count", {48'b0, underflow_cnt_o}, 64'd32);

    // Counter preloaded near the top to reach saturation within one period.
    dut.ufl_q = 16'hFFF0;
    m_ufl = 16'hFFF0;
    for (int i = 0; i < 66; i++) cycle(1'b0, 1'b0, 64'h0, 2'b00);
    chk("ufl_saturate", {48'b0, underflow_cnt_o}, 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_scrambler_seq.md
TX_SCRAMBLER_SEQ -- requirements
Module: tx_scrambler_seq

Interface
REQ-001 SHALL have parameter IDLE_BLOCK, default 64'h0000_0000_0000_001E, meaning payload inserted on underflow (10GBASE-R idle control block).
REQ-002 SHALL have parameter SCR_INIT, default 58'h3FF_FFFF_FFFF_FFFF, meaning scrambler state after reset.
REQ-003 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_i, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port blk_data_i, input, 64, unscrambled 66b block payload, bit 0 first on line.
REQ-006 SHALL have port blk_head_i, input, 2, sync header (2'b01 data, 2'b10 control).
REQ-007 SHALL have port blk_valid_i, input, 1, block present on blk_data_i/blk_head_i.
REQ-008 SHALL have port blk_ready_o, output, 1, block accepted when blk_valid_i & blk_ready_o at a rising edge.
REQ-009 SHALL have port data_o, output, 32, scrambled half-block to the 66b/64b gearbox.
REQ-010 SHALL have port head_o, output, 2, sync header, unscrambled, to the gearbox.
REQ-011 SHALL have port sequence_o, output, 7, gearbox sequence count, 0..65.
REQ-012 SHALL have port underflow_cnt_o, output, 16, count of inserted idle blocks, saturating.

Function
REQ-013 SHALL register data_o, head_o, sequence_o; all change only at rising edges.
REQ-014 SHALL advance sequence_o by 1 every cycle, 65 wrapping to 0; no holds.
REQ-015 SHALL drive blk_ready_o = 1 combinationally iff next sequence is even and below 64: sequence_o odd and not 63, or sequence_o == 65.
REQ-016 SHALL, at an edge where blk_ready_o=1, load the accepted block, or IDLE_BLOCK with header 2'b10 if blk_valid_i=0.
REQ-017 SHALL, on the even sequence cycle following the load, output scrambled payload bits [31:0] on data_o and the block header on head_o.
REQ-018 SHALL, on the following odd sequence cycle, output scrambled payload bits [63:32] on data_o and head_o = 2'b00.
REQ-019 SHALL give 1-cycle latency from accepting edge to first half-word on data_o.
REQ-020 SHALL, during sequence_o 64 and 65 (pause), drive data_o = 0 and head_o = 2'b00; no scrambler advance.
REQ-021 SHALL scramble with the self-synchronous polynomial 1 + x^39 + x^58: out[i] = in[i] ^ s[i-39] ^ s[i-58], s being prior scrambled output bits; bit 0 processed first.
REQ-022 SHALL advance the 58-bit scrambler state exactly 64 bits per block, header bits excluded.
REQ-023 SHALL scramble inserted idle blocks like any other block.
REQ-024 SHALL increment underflow_cnt_o by 1 per inserted idle block, holding at 16'hFFFF.
REQ-025 SHALL ignore blk_data_i/blk_head_i whenever blk_ready_o=0; blk_valid_i high at such edges is not an error, block is held by upstream.
REQ-026 SHALL treat blk_head_i values 2'b00/2'b11 as data, passing them unchanged.

Reset
REQ-027 SHALL, while rst_i=1 at an edge, set sequence_o=65, data_o=0, head_o=0, underflow_cnt_o=0, scrambler state=SCR_INIT, discard any half-sent block.
REQ-028 SHALL drive blk_ready_o=0 while rst_i=1; first cycle after reset release SHALL have blk_ready_o=1 (sequence_o=65).
REQ-029 SHALL, on reset mid-block, emit no remaining half of that block after release.

Verification
REQ-030 Reset release, blk_valid_i held 1 with incrementing payloads -> sequence_o 0,1,...,65,0; blk_ready_o high 32 of every 66 cycles; headers on even cycles 0..62 only.
REQ-031 blk_valid_i=0 for all cycles -> idle blocks, head_o=2'b10 on even cycles, underflow_cnt_o=32 after one 66-cycle period.
REQ-032 Block 64'h0, header 2'b01, from SCR_INIT -> data_o matches bit-serial reference model of 1+x^39+x^58; descrambled in bench equals input.
REQ-033 Sequence 64/65 with blk_valid_i=1 -> blk_ready_o=0, data_o=0, head_o=0; held block emitted at sequence 0.
REQ-034 rst_i pulse for 1 cycle at sequence_o=10 -> next cycle sequence_o=65, data_o=0, underflow_cnt_o=0; scrambler restarts from SCR_INIT.
REQ-035 Force 65536 underflows -> underflow_cnt_o saturates at 16'hFFFF.
